// File: rtl/skolem_chk_pkg.sv
// Shared types and helpers for the lshr/sle Skolem witness checker.
package skolem_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CMP   = 2'd2,
        ST_RESP  = 2'd3
    } chk_state_e;

    localparam int CHK_WIDTH = 4;
    localparam int CNTSH_W   = $clog2(CHK_WIDTH + 1);

    // Operands are sign-extended to this width by the caller so one helper serves any WIDTH.
    localparam int SLE_W = 64;
    typedef logic signed [SLE_W-1:0] wide_t;

    function automatic logic sle(input wide_t a, input wide_t b);
        return a <= b;
    endfunction

    function automatic logic inv_ic(input wide_t s, input wide_t t);
        return !t[SLE_W-1] || sle(s, t);
    endfunction

endpackage

// File: rtl/skolem_chk_serial_shr.sv
// One-bit-per-cycle logical right shifter with a saturating shift-amount counter.
module skolem_chk_serial_shr #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] s_i,
    input  logic [WIDTH-1:0] amt_i,
    output logic [WIDTH-1:0] sh_o,
    output logic             done_o
);

    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Shifting more than WIDTH times is indistinguishable from WIDTH times.
    always_comb begin
        cnt_d = CW'(amt_i);
        if (amt_i >= WIDTH'(WIDTH)) begin
            cnt_d = CW'(WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= cnt_d;
        end else if (shift_en_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            sh_q <= s_i;
        end else if (shift_en_i) begin
            sh_q <= sh_q >> 1;
        end
    end

    assign sh_o   = sh_q;
    assign done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/skolem_inv_lshr_sle_checker.sv
// Checks a witness x for (s >>l x) <=s t and flags failures under the invertibility condition.
// Optional statistics counters are enabled by defining SKOLEM_CHK_STATS_EN.
module skolem_inv_lshr_sle_checker
    import skolem_chk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_shifted,
    output logic             out_ok,
    output logic             out_ic,
    output logic             out_viol
`ifdef SKOLEM_CHK_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_checked,
    output logic [CNT_W-1:0] stat_fail,
    output logic [CNT_W-1:0] stat_viol
`endif
);

    localparam int SH_CW = $clog2(WIDTH + 1);

    chk_state_e       state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_shifted_q;
    logic             out_ok_q;
    logic             out_ic_q;
    logic             out_viol_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] t_q;

    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] sh;
    logic             sh_done;
    logic             ok_d;
    logic             ic_d;

    assign accept    = (state_q == ST_IDLE) && in_valid;
    assign handshake = out_valid_q && out_ready;

    skolem_chk_serial_shr #(
        .WIDTH (WIDTH),
        .CW    (SH_CW)
    ) u_shr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .shift_en_i (state_q == ST_SHIFT),
        .s_i        (in_s),
        .amt_i      (in_x),
        .sh_o       (sh),
        .done_o     (sh_done)
    );

    assign ok_d = sle(SLE_W'($signed(sh)), SLE_W'($signed(t_q)));
    assign ic_d = inv_ic(SLE_W'($signed(s_q)), SLE_W'($signed(t_q)));

    always_ff @(posedge clk) begin
        if (accept) begin
            s_q <= in_s;
            t_q <= in_t;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_shifted_q <= '0;
            out_ok_q      <= 1'b0;
            out_ic_q      <= 1'b0;
            out_viol_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        state_q    <= (in_x == '0) ? ST_CMP : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sh_done) begin
                        state_q <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    out_shifted_q <= sh;
                    out_ok_q      <= ok_d;
                    out_ic_q      <= ic_d;
                    out_viol_q    <= ic_d & ~ok_d;
                    out_valid_q   <= 1'b1;
                    state_q       <= ST_RESP;
                end
                ST_RESP: begin
                    // Input re-opens only after the result has been taken.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_shifted = out_shifted_q;
    assign out_ok      = out_ok_q;
    assign out_ic      = out_ic_q;
    assign out_viol    = out_viol_q;

`ifdef SKOLEM_CHK_STATS_EN
    logic [CNT_W-1:0] checked_q;
    logic [CNT_W-1:0] fail_q;
    logic [CNT_W-1:0] viol_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            checked_q <= '0;
            fail_q    <= '0;
            viol_q    <= '0;
        end else if (handshake) begin
            checked_q <= sat_inc(checked_q);
            if (!out_ok_q) begin
                fail_q <= sat_inc(fail_q);
            end
            if (out_viol_q) begin
                viol_q <= sat_inc(viol_q);
            end
        end
    end

    assign stat_checked = checked_q;
    assign stat_fail    = fail_q;
    assign stat_viol    = viol_q;
`else
    logic unused_stats;
    logic unused_handshake;
    assign unused_stats     = ^CNT_W'(0);
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_skolem_inv_lshr_sle_checker.sv
// Scoreboard bench for skolem_inv_lshr_sle_checker (stats ports follow SKOLEM_CHK_STATS_EN).
module tb_skolem_inv_lshr_sle_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_s;
    logic [3:0] in_t;
    logic [3:0] in_x;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_shifted;
    logic       out_ok;
    logic       out_ic;
    logic       out_viol;
`ifdef SKOLEM_CHK_STATS_EN
    logic [15:0] stat_checked;
    logic [15:0] stat_fail;
    logic [15:0] stat_viol;
`endif

    skolem_inv_lshr_sle_checker #(.WIDTH(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_s        (in_s),
        .in_t        (in_t),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_shifted (out_shifted),
        .out_ok      (out_ok),
        .out_ic      (out_ic),
        .out_viol    (out_viol)
`ifdef SKOLEM_CHK_STATS_EN
        ,
        .stat_checked (stat_checked),
        .stat_fail    (stat_fail),
        .stat_viol    (stat_viol)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sh;
        logic       ok;
        logic       ic;
        logic       viol;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x);
        exp_t e;
        e.sh   = s >> x;
        e.ok   = $signed(e.sh) <= $signed(t);
        e.ic   = !t[3] || ($signed(s) <= $signed(t));
        e.viol = e.ic & ~e.ok;
        e.lat  = 8'((x > 4'd4) ? 4'd4 : x) + 8'd2;
        return e;
    endfunction

    // Drive one tuple, wait for its result, optionally stall it, then take it.
    task automatic apply(input logic [3:0] s, input logic [3:0] t, input logic [3:0] x, input int hold);
        exp_t e;
        int   w;
        int   lat;
        sb.push_back(model(s, t, x));
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_s = s; in_t = t; in_x = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_s = 4'($urandom); in_t = 4'($urandom); in_x = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("latency", 32'(lat), 32'(e.lat));
            chk("out_shifted", 32'(out_shifted), 32'(e.sh));
            chk("out_ok", 32'(out_ok), 32'(e.ok));
            chk("out_ic", 32'(out_ic), 32'(e.ic));
            chk("out_viol", 32'(out_viol), 32'(e.viol));
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1; in_s = 4'hF; in_t = 4'h0; in_x = 4'h0;
                @(posedge clk); #1;
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_out_shifted", 32'(out_shifted), 32'(e.sh));
                chk("stall_out_ok", 32'(out_ok), 32'(e.ok));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_hs", 32'(out_valid), 32'd0);
        chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_s = '0; in_t = '0; in_x = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bits", 32'({out_shifted, out_ok, out_ic, out_viol}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        apply(4'b1000, 4'b1111, 4'd0, 0);
        apply(4'b0111, 4'b0010, 4'd1, 0);
        apply(4'b0111, 4'b0010, 4'd7, 0);
        apply(4'b0111, 4'b1110, 4'd0, 0);
`ifdef SKOLEM_CHK_STATS_EN
        chk("stat_checked", 32'(stat_checked), 32'd4);
        chk("stat_fail", 32'(stat_fail), 32'd2);
        chk("stat_viol", 32'(stat_viol), 32'd1);
`endif

        apply(4'b0110, 4'b0001, 4'd2, 3);
        // Most-negative bound: only an exact match passes.
        apply(4'b1000, 4'b1000, 4'd0, 0);
        apply(4'b1000, 4'b1000, 4'd1, 0);
        apply(4'b1111, 4'b1000, 4'd4, 0);
        for (int i = 0; i < 24; i++) begin
            apply(4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
        end

        // Reset mid-shift drops the tuple.
        in_valid = 1'b1; in_s = 4'b0111; in_t = 4'b0010; in_x = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_shifted", 32'(out_shifted), 32'd0);
        seen = 0;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("midrst_no_output", 32'(seen), 32'd0);
`ifdef SKOLEM_CHK_STATS_EN
        chk("midrst_stat_checked", 32'(stat_checked), 32'd0);
`endif
        apply(4'b0111, 4'b0010, 4'd3, 0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/skolem_inv_lshr_sle_checker.md
Name: skolem_inv_lshr_sle_checker

Overview:
- Sequential checker for the lshr/sle invertibility benchmark family. It takes the other end of the Skolem path: given operands s and t plus a candidate witness x, it decides whether x satisfies (s >>l x) <=s t.
- It also evaluates the invertibility condition (IC) and flags any witness that fails while the IC holds.
- It sits downstream of the combinational Skolem-function blocks in the equivalence/validation harness and uses a valid/ready stream in and out.

Parameters:
- WIDTH, 4, bit width of s, t, x.
- CNT_W, 16, width of the statistics counters; only used with the optional feature.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input tuple valid.
- in_ready  out  1  checker can accept a tuple.
- in_s  in  WIDTH  shifted operand s, unsigned for the shift.
- in_t  in  WIDTH  bound t, two's complement.
- in_x  in  WIDTH  candidate witness (shift amount).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_shifted  out  WIDTH  value of s >>l x.
- out_ok  out  1  (s >>l x) <=s t.
- out_ic  out  1  invertibility condition: (t >=s 0) | (s <=s t).
- out_viol  out  1  out_ic & ~out_ok, i.e. the witness is wrong.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_shifted, out_ok, out_ic and out_viol all 0; counters 0.
- rst has priority over every other event, including mid-SHIFT and mid-RESP. Any in-flight tuple is dropped with no output.
- FSM states: IDLE, SHIFT, CMP, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, register s, t and sh=s.
  - Set cnt = (x >= WIDTH) ? WIDTH : x. cnt is saturated and is clog2(WIDTH+1) bits wide.
  - Next state is SHIFT if cnt != 0, otherwise CMP.
- SHIFT:
  - Each cycle: sh <= {1'b0, sh[WIDTH-1:1]} and cnt <= cnt-1.
  - Go to CMP when cnt==1.
  - in_ready=0.
- CMP:
  - Register out_shifted=sh and out_ok = signed(sh) <= signed(t).
  - Register out_ic from the registered s and t, and out_viol.
  - Go to RESP.
- RESP:
  - out_valid=1. Outputs are held stable until out_valid & out_ready, then go to IDLE.
  - in_ready=0, so a new tuple is accepted only in the cycle after the handshake. There is no input/output overlap.
- Latency: an accept edge at cycle k gives out_valid high from cycle k+2+cnt. Range is 2 cycles (x=0) to WIDTH+2 cycles (x >= WIDTH).
- x >= WIDTH always yields out_shifted=0.
- Signed compare uses the MSB as the sign. With t = -2^(WIDTH-1), out_ok holds only when sh equals t.
- in_* are sampled only at the accept edge. Changes while busy are ignored.
- out_* keep their last value after the handshake. out_valid=0 marks them stale.

Optional Feature:
- Macro: SKOLEM_CHK_STATS_EN.
- When defined, adds these output ports, each CNT_W wide and zero on rst:
  - stat_checked: +1 per output handshake.
  - stat_fail: +1 per handshake with out_ok=0.
  - stat_viol: +1 per handshake with out_viol=1.
- All counters saturate at all-ones.
- When undefined, the ports and counters are absent and the core behaviour is identical.

Decomposition:
- Package skolem_chk_pkg holds:
  - the state enum (IDLE, SHIFT, CMP, RESP);
  - localparam CNTSH_W = $clog2(WIDTH+1);
  - a function sle(a, b) for the signed <= compare;
  - a function inv_ic(s, t).
- One natural sub-module is skolem_chk_serial_shr: load, shift-enable, count-down and done. It is instantiated once by the FSM top.

Test Plan:
- s=4'b1000, t=4'b1111, x=0: out_shifted=1000, ok=1, ic=1, viol=0. out_valid rises 2 cycles after accept.
- s=0111, t=0010, x=1: out_shifted=0011, ok=0, ic=1, viol=1. Latency 3.
- s=0111, t=0010, x=4'd7: saturates to 4 shifts. out_shifted=0000, ok=1. Latency 6.
- s=0111, t=1110, x=0: ok=0, ic=0, viol=0.
- Backpressure: hold out_ready=0 for 3 cycles in RESP. out_valid and data stay stable, in_ready=0, and an in_valid offered meanwhile is not consumed.
- Assert rst for 1 cycle during SHIFT with x=3. Next cycle: IDLE, in_ready=1, out_valid=0, no result emitted. With SKOLEM_CHK_STATS_EN, after the first four cases: stat_checked=4, stat_fail=2, stat_viol=1.
